shift_unit_seq: RTL

SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

---
 rtl/shift_unit_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/shift_unit_seq.sv
// Sequential barrel shifter: one log-shift stage per clock, fixed latency
// regardless of amount. SRL / SRA / SLL / ROR with a lost-bits flag.
module shift_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] X,
  input  logic [31:0]      Y,
  output logic [WIDTH-1:0] Z,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int CNT_W = (LOG2W > 1) ? $clog2(LOG2W) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(LOG2W - 1);
  localparam logic [LOG2W:0]   FULL_ROT   = (LOG2W + 1)'(WIDTH);
  localparam logic [LOG2W:0]   ONE_SH     = (LOG2W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q;
  logic             sign_q;
  logic             sat_q;
  logic [LOG2W-1:0] amt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] work_q, work_nx;
  logic             vacc_q, vacc_nx;
  logic             lost;
  logic             capture;
  logic [LOG2W:0]   sh;
  logic [WIDTH-1:0] lo_mask, hi_mask;

  // A new operation may only be accepted when no shift is in flight.
  assign capture = start && (state_q != SHIFT);
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values and simulation matches the synthesized
  // hardware regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_STAGE) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One shift stage: distance 2^cnt, applied only when that amount bit is set
  // ---------------------------------------------------------------------------
  always_comb begin
    sh      = ONE_SH << cnt_q;
    lo_mask = ~({WIDTH{1'b1}} << sh);
    hi_mask = ~({WIDTH{1'b1}} >> sh);
    work_nx = work_q;
    lost    = 1'b0;
    if (sat_q) begin
      // Out-of-range amount: the whole operand is discarded in one go and
      // replaced by the fill pattern; later stages see only fill bits.
      work_nx = {WIDTH{(op_q == OP_SRA) && sign_q}};
      lost    = |work_q;
    end else if (amt_q[cnt_q]) begin
      case (op_q)
        OP_SRL: begin
          work_nx = work_q >> sh;
          lost    = |(work_q & lo_mask);
        end
        OP_SRA: begin
          work_nx = (work_q >> sh) | ({WIDTH{sign_q}} & hi_mask);
          lost    = |(work_q & lo_mask);
        end
        OP_SLL: begin
          work_nx = work_q << sh;
          lost    = |(work_q & hi_mask);
        end
        default: begin
          work_nx = (work_q >> sh) | (work_q << (FULL_ROT - sh));
          lost    = 1'b0;
        end
      endcase
    end
    vacc_nx = vacc_q | lost;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers and result outputs
  // ---------------------------------------------------------------------------
  // NOTE: the operand registers are reset along with the outputs; they are a
  // handful of flops, and a defined post-reset value keeps X out of the
  // lost-bits logic during bring-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_SRL;
      sign_q <= 1'b0;
      sat_q  <= 1'b0;
      amt_q  <= '0;
      cnt_q  <= '0;
      work_q <= '0;
      vacc_q <= 1'b0;
      Z      <= '0;
      V      <= 1'b0;
    end else if (capture) begin
      op_q   <= op_t'(OP);
      sign_q <= X[WIDTH-1];
      sat_q  <= (op_t'(OP) != OP_ROR) && (|Y[31:LOG2W]);
      amt_q  <= Y[LOG2W-1:0];
      cnt_q  <= '0;
      work_q <= X;
      vacc_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      work_q <= work_nx;
      vacc_q <= vacc_nx;
      cnt_q  <= cnt_q + 1'b1;
      // Results publish on the final stage edge, i.e. as DONE is entered.
      if (cnt_q == LAST_STAGE) begin
        Z <= work_nx;
        V <= vacc_nx;
      end
    end
  end

endmodule
